balance_cntrl_slew: RTL

Parametrised, self-contained Segway balance controller. Computes a PID command from pitch and pitch rate, scales it by a soft-start ramp, mixes in steering, slew-limits each wheel command, and flags excessive speed. Sits between inertial_intf/A2D_intf and the motor drive, with a 2-cycle pipeline and a per-sample output-valid pulse.

---
 rtl/balance_cntrl_slew.sv | 200 ++++++++++++++++++++
 1 files changed

// File: rtl/balance_cntrl_slew.sv
// Segway balance controller: PID on pitch, soft-start scaling, steering mix,
// per-wheel slew limiting and over-speed flag in a two-stage pipeline.
module balance_cntrl_slew #(
    parameter int SW       = 12,
    parameter int SLEW     = 64,
    parameter int TF_THR   = 1536,
    parameter bit fast_sim = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pwr_up,
    input  logic                 vld,
    input  logic                 rider_off,
    input  logic                 en_steer,
    input  logic signed [15:0]   ptch,
    input  logic signed [15:0]   ptch_rt,
    input  logic        [11:0]   steer_pot,
    output logic signed [SW-1:0] lft_spd,
    output logic signed [SW-1:0] rght_spd,
    output logic                 too_fast,
    output logic                 spd_vld
);

    // Internal arithmetic width: wide enough for the PID sum and for pid*ss.
    localparam int WW = (SW + 8 > 20) ? SW + 8 : 20;

    localparam logic signed [WW-1:0] SPD_MAX   = WW'(2**(SW-1) - 1);
    localparam logic signed [WW-1:0] SPD_MIN   = WW'(-(2**(SW-1)));
    localparam logic signed [WW-1:0] SLEW_W    = WW'(SLEW);
    localparam logic signed [WW-1:0] TF_W      = WW'(TF_THR);
    localparam logic signed [18:0]   INTEG_MAX = 19'sd131071;
    localparam logic signed [18:0]   INTEG_MIN = -19'sd131071;
    localparam logic        [15:0]   SS_STEP   = fast_sim ? 16'd256 : 16'd1;

    typedef enum logic [1:0] {
        ST_OFF  = 2'd0,
        ST_RAMP = 2'd1,
        ST_RUN  = 2'd2
    } state_e;

    function automatic logic signed [WW-1:0] ext(input logic signed [SW-1:0] x);
        return {{(WW-SW){x[SW-1]}}, x};
    endfunction

    // Full two's-complement saturation to SW bits.
    function automatic logic signed [SW-1:0] sat_sw(input logic signed [WW-1:0] x);
        if (x > SPD_MAX) return SW'(SPD_MAX);
        if (x < SPD_MIN) return SW'(SPD_MIN);
        return SW'(x);
    endfunction

    function automatic logic signed [SW-1:0] slew_step(input logic signed [SW-1:0] prev,
                                                       input logic signed [SW-1:0] tgt);
        logic signed [WW-1:0] diff;
        logic signed [WW-1:0] nxt;
        diff = ext(tgt) - ext(prev);
        if (diff > SLEW_W)       nxt = ext(prev) + SLEW_W;
        else if (diff < -SLEW_W) nxt = ext(prev) - SLEW_W;
        else                     nxt = ext(tgt);
        return SW'(nxt);
    endfunction

    function automatic logic over_thr(input logic signed [SW-1:0] x);
        logic signed [WW-1:0] mag;
        mag = x[SW-1] ? -ext(x) : ext(x);
        return mag > TF_W;
    endfunction

    state_e                state_q, state_d;
    logic [15:0]           ss_cnt_q, ss_cnt_d;
    logic [16:0]           ss_sum;
    logic [15:0]           ss_inc;
    logic signed [17:0]    integ_q, integ_d;
    logic signed [SW-1:0]  pid_q, pid_d;
    logic                  vld1_q;
    logic signed [SW-1:0]  lft_q, rght_q;
    logic                  too_fast_q, spd_vld_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        ss_sum  = {1'b0, ss_cnt_q} + {1'b0, SS_STEP};
        ss_inc  = ss_sum[16] ? 16'hFFFF : ss_sum[15:0];
        state_d = state_q;
        unique case (state_q)
            ST_OFF:  state_d = ST_RAMP;
            ST_RAMP: if (ss_inc == 16'hFFFF) state_d = ST_RUN;
            ST_RUN:  state_d = ST_RUN;
            default: state_d = ST_OFF;
        endcase
        if (!pwr_up) state_d = ST_OFF;

        ss_cnt_d = '0;
        if (pwr_up && state_q != ST_OFF) ss_cnt_d = ss_inc;
    end

    logic signed [9:0]    err;
    logic signed [18:0]   integ_sum;
    logic signed [17:0]   integ_sat;
    logic signed [WW-1:0] err_w, p_term, i_term, d_term;
    logic signed [17:0]   i_sh;
    logic signed [15:0]   d_sh;
    logic                 integ_clr;

    // Stage 1: P, I (using the freshly accumulated integrator) and D terms.
    always_comb begin
        err = ptch[9:0];
        if (ptch > 16'sd511)       err = 10'sd511;
        else if (ptch < -16'sd512) err = -10'sd512;

        integ_sum = {integ_q[17], integ_q} + {{9{err[9]}}, err};
        integ_sat = integ_sum[17:0];
        if (integ_sum > INTEG_MAX)      integ_sat = INTEG_MAX[17:0];
        else if (integ_sum < INTEG_MIN) integ_sat = INTEG_MIN[17:0];

        integ_clr = rider_off || !pwr_up || state_q == ST_OFF;
        integ_d   = integ_q;
        if (integ_clr) integ_d = '0;
        else if (vld)  integ_d = integ_sat;

        err_w  = {{(WW-10){err[9]}}, err};
        p_term = (err_w <<< 2) + err_w;
        i_sh   = integ_d >>> 6;
        i_term = {{(WW-18){i_sh[17]}}, i_sh};
        d_sh   = ptch_rt >>> 6;
        d_term = -{{(WW-16){d_sh[15]}}, d_sh};

        pid_d = pid_q;
        if (vld) pid_d = sat_sw(p_term + i_term + d_term);
    end

    logic [7:0]           ss;
    logic signed [WW-1:0] ss_w, pid_prod, pid_ss, mix;
    logic [11:0]          pot_clip;
    logic signed [14:0]   st, st3, mix_sh;
    logic signed [SW-1:0] tgt_l, tgt_r, lft_nxt, rght_nxt;

    // Stage 2: soft-start scaling, steering mix and slew limiting.
    always_comb begin
        ss       = (state_q == ST_OFF) ? 8'd0 : ss_cnt_q[15:8];
        ss_w     = {{(WW-8){1'b0}}, ss};
        pid_prod = ext(pid_q) * ss_w;
        pid_ss   = pid_prod >>> 8;

        pot_clip = steer_pot;
        if (steer_pot < 12'h200)      pot_clip = 12'h200;
        else if (steer_pot > 12'hE00) pot_clip = 12'hE00;
        st     = $signed({3'b000, pot_clip}) - 15'sd2048;
        st3    = st * 15'sd3;
        mix_sh = st3 >>> 4;

        // Steering is ignored while OFF so the wheels wind down to zero.
        mix = '0;
        if (en_steer && state_q != ST_OFF) mix = {{(WW-15){mix_sh[14]}}, mix_sh};

        tgt_l    = sat_sw(pid_ss + mix);
        tgt_r    = sat_sw(pid_ss - mix);
        lft_nxt  = slew_step(lft_q, tgt_l);
        rght_nxt = slew_step(rght_q, tgt_r);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers
    // sample their inputs from the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_OFF;
            ss_cnt_q <= '0;
            integ_q  <= '0;
            pid_q    <= '0;
            vld1_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            ss_cnt_q <= ss_cnt_d;
            integ_q  <= integ_d;
            pid_q    <= pid_d;
            vld1_q   <= vld;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lft_q      <= '0;
            rght_q     <= '0;
            too_fast_q <= 1'b0;
            spd_vld_q  <= 1'b0;
        end else begin
            spd_vld_q <= vld1_q;
            if (vld1_q) begin
                lft_q      <= lft_nxt;
                rght_q     <= rght_nxt;
                too_fast_q <= over_thr(lft_nxt) || over_thr(rght_nxt);
            end
        end
    end

    assign lft_spd  = lft_q;
    assign rght_spd = rght_q;
    assign too_fast = too_fast_q;
    assign spd_vld  = spd_vld_q;

endmodule
